rgb_pair_writer: RTL and testbench
==================================

Name: rgb_pair_writer

Overview:
- Downstream stage of the YUV-to-RGB colourspace converter.
- Accepts one converted pixel pair per transfer: clipped 8-bit R/G/B for the even pixel and for the odd pixel.
- Buffers pairs in a small FIFO and packs each pair into three 16-bit words.
- Writes those words sequentially into the RGB region of SRAM, where the VGA reader later fetches them.

Parameters:
- RGB_OFFSET, 18'd146944: SRAM word address of pair 0, word 0.
- PIXEL_PAIRS, 38400: pairs per frame (320x240/2); 3 words per pair, so the last word lands at address 262143.
- FIFO_DEPTH, 2: pair entries buffered (48 bits each); must be at least 1.

Ports:
- Clock_50  in  1  50 MHz system clock.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  one-cycle pulse; begins a frame. Ignored while Busy=1.
- Pair_valid  in  1  upstream holds a pair.
- Pair_ready  out  1  writer accepts the pair this cycle.
- R_even, G_even, B_even  in  8 each  even-pixel colour.
- R_odd, G_odd, B_odd  in  8 each  odd-pixel colour.
- Grant  in  1  SRAM port available to this block this cycle.
- SRAM_address  out  18  write address.
- SRAM_write_data  out  16  write data.
- SRAM_we_n  out  1  active-low write enable.
- Busy  out  1  frame in progress.
- Done  out  1  one-cycle pulse, frame fully written.
- Pair_count  out  16  pairs fully written this frame.

Behaviour:
- One clock (Clock_50); reset is synchronous and active-high (Reset). All outputs are registered.
- Reset values:
  - state=IDLE, FIFO empty, address counter=RGB_OFFSET, accepted count=0.
  - SRAM_we_n=1, SRAM_address=0, SRAM_write_data=0.
  - Busy=0, Done=0, Pair_ready=0, Pair_count=0.
- Reset mid-frame: SRAM_we_n=1 on the next edge, FIFO flushed, no partial pair completed.
- Handshake:
  - Transfer occurs when Pair_valid=1 and Pair_ready=1 at the rising edge.
  - Pair_ready=1 only when Busy=1, FIFO occupancy < FIFO_DEPTH, and accepted count < PIXEL_PAIRS.
  - Pair_ready is derived from registered occupancy, so a full FIFO never accepts, even if it pops the same cycle.
  - Push and pop in the same cycle leave occupancy unchanged.
- Packing:
  - word0 = {R_even, G_even}
  - word1 = {B_even, R_odd}
  - word2 = {G_odd, B_odd}
- Address counter starts at RGB_OFFSET at Start and increments by 1 per granted write, so pair k word j is at RGB_OFFSET + 3k + j. No wrap; the frame ends exactly at 18'h3FFFF.
- FSM states: IDLE, FETCH, W0, W1, W2, DONE.
  - IDLE: on Start, clear counters, Busy<=1, go to FETCH.
  - FETCH: if FIFO non-empty, pop into a 48-bit pair register and go to W0; otherwise stay.
  - Wj with Grant=1: SRAM_we_n<=0, SRAM_address<=counter, SRAM_write_data<=wordj, counter++, advance.
  - Wj with Grant=0: SRAM_we_n<=1, hold state, counter and pair register.
  - Leaving W2 (granted): Pair_count++.
    - If the new count equals PIXEL_PAIRS, go to DONE.
    - Else if the FIFO is non-empty, pop and go directly to W0 (no FETCH bubble).
    - Else go to FETCH.
  - Any non-write cycle drives SRAM_we_n<=1.
  - DONE: Done<=1 for one cycle, Busy<=0, go to IDLE.
- Throughput: one pair per 3 cycles with continuous Grant.
- Latency: a pair accepted in cycle n into an empty FIFO while in FETCH is popped in cycle n+1. Its word0 write is visible on the SRAM outputs in cycle n+3; word1 in n+4; word2 in n+5.
- Start while Busy is ignored; counters are unaffected.
- Pairs offered after PIXEL_PAIRS have been accepted are refused (Pair_ready=0).

Test Plan:
- Reset, then Start, then one pair R/G/B even=10,20,30 and odd=40,50,60, Grant=1:
  - writes 0x0A14 @146944, 0x1E28 @146945, 0x323C @146946 on consecutive cycles;
  - Pair_count=1.
- Continuous Pair_valid with Grant=1 for 4 pairs:
  - 12 back-to-back writes, SRAM_we_n low in 12 consecutive cycles;
  - Pair_ready deasserts whenever the FIFO holds 2 pairs.
- Grant held low for 5 cycles during W1:
  - SRAM_we_n=1 and address/data frozen;
  - after Grant returns, word1 and word2 are written at the expected addresses;
  - no word is duplicated or skipped.
- Full frame with PIXEL_PAIRS=38400:
  - last write @262143;
  - Done pulses exactly once, Busy falls, Pair_count=38400;
  - an extra pair offered is not accepted.
- Reset asserted in W2 with a full FIFO:
  - next cycle SRAM_we_n=1, Busy=0, Pair_ready=0;
  - after a new Start, the first write is @146944.
- Start pulsed again mid-frame: ignored, address sequence continues uninterrupted.

Source files
------------

// File: rtl/rgb_pair_writer.sv
// rtl/rgb_pair_writer.sv - buffers RGB pixel pairs and writes them as three 16-bit SRAM words
module rgb_pair_writer #(
    parameter logic [17:0] RGB_OFFSET  = 18'd146944,
    parameter int unsigned PIXEL_PAIRS = 38400,
    parameter int unsigned FIFO_DEPTH  = 2
) (
    input  logic        Clock_50,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Pair_valid,
    output logic        Pair_ready,
    input  logic [7:0]  R_even,
    input  logic [7:0]  G_even,
    input  logic [7:0]  B_even,
    input  logic [7:0]  R_odd,
    input  logic [7:0]  G_odd,
    input  logic [7:0]  B_odd,
    input  logic        Grant,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] Pair_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [15:0]      PAIRS    = 16'(PIXEL_PAIRS);
    localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_W0, S_W1, S_W2, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [47:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic [47:0]      pair_q, pair_d;
    logic [17:0]      addr_cnt_q, addr_cnt_d, addr_q, addr_d;
    logic [15:0]      acc_q, acc_d, pair_cnt_q, pair_cnt_d, data_q, data_d;
    logic             we_n_q, we_n_d, busy_q, busy_d, done_q, done_d, ready_q, ready_d;
    logic             push, pop, write_now;
    logic [15:0]      word;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign push = Pair_valid & ready_q;

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            pair_q     <= '0;
            addr_cnt_q <= RGB_OFFSET;
            acc_q      <= '0;
            pair_cnt_q <= '0;
            we_n_q     <= 1'b1;
            addr_q     <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            pair_q     <= pair_d;
            addr_cnt_q <= addr_cnt_d;
            acc_q      <= acc_d;
            pair_cnt_q <= pair_cnt_d;
            we_n_q     <= we_n_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge Clock_50) begin
        if (push) mem_q[wr_ptr_q] <= {R_even, G_even, B_even, R_odd, G_odd, B_odd};
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE:  if (Start) state_d = S_FETCH;
            S_FETCH: if (occ_q != '0) begin
                pop     = 1'b1;
                state_d = S_W0;
            end
            S_W0:    if (Grant) state_d = S_W1;
            S_W1:    if (Grant) state_d = S_W2;
            S_W2:    if (Grant) begin
                if (pair_cnt_q + 16'd1 == PAIRS) begin
                    state_d = S_DONE;
                end else if (occ_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_W0;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        pair_d     = pair_q;
        addr_cnt_d = addr_cnt_q;
        acc_d      = acc_q;
        pair_cnt_d = pair_cnt_q;
        we_n_d     = 1'b1;
        addr_d     = addr_q;
        data_d     = data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        unique case (state_q)
            S_W1:    word = pair_q[31:16];
            S_W2:    word = pair_q[15:0];
            default: word = pair_q[47:32];
        endcase
        write_now = Grant && (state_q == S_W0 || state_q == S_W1 || state_q == S_W2);

        if (write_now) begin
            we_n_d     = 1'b0;
            addr_d     = addr_cnt_q;
            data_d     = word;
            addr_cnt_d = addr_cnt_q + 18'd1;
            if (state_q == S_W2) pair_cnt_d = pair_cnt_q + 16'd1;
        end
        if (pop) begin
            pair_d   = mem_q[rd_ptr_q];
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
            acc_d    = acc_q + 16'd1;
        end
        if (push && !pop)      occ_d = occ_q + CNT_W'(1);
        else if (!push && pop) occ_d = occ_q - CNT_W'(1);

        if (state_q == S_IDLE && Start) begin
            addr_cnt_d = RGB_OFFSET;
            acc_d      = '0;
            pair_cnt_d = '0;
            busy_d     = 1'b1;
        end
        if (state_q == S_DONE) begin
            done_d = 1'b1;
            busy_d = 1'b0;
        end
        // Registered ready equals the accept condition evaluated on the registered state.
        ready_d = busy_d && (occ_d < DEPTH) && (acc_d < PAIRS);
    end

    assign Pair_ready      = ready_q;
    assign SRAM_address    = addr_q;
    assign SRAM_write_data = data_q;
    assign SRAM_we_n       = we_n_q;
    assign Busy            = busy_q;
    assign Done            = done_q;
    assign Pair_count      = pair_cnt_q;

endmodule

// File: tb/tb_rgb_pair_writer.sv
// tb/tb_rgb_pair_writer.sv - scoreboard bench for rgb_pair_writer
module tb_rgb_pair_writer;

    localparam int PP = 16;
    localparam logic [17:0] OFF = 18'h3FFFF - 18'(3 * PP) + 18'd1;

    logic        Clock_50 = 1'b0;
    logic        Reset, Start, Pair_valid, Pair_ready, Grant;
    logic [7:0]  R_even, G_even, B_even, R_odd, G_odd, B_odd;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data, Pair_count;
    logic        SRAM_we_n, Busy, Done;

    rgb_pair_writer #(.RGB_OFFSET(OFF), .PIXEL_PAIRS(PP), .FIFO_DEPTH(2)) dut (
        .Clock_50(Clock_50), .Reset(Reset), .Start(Start),
        .Pair_valid(Pair_valid), .Pair_ready(Pair_ready),
        .R_even(R_even), .G_even(G_even), .B_even(B_even),
        .R_odd(R_odd), .G_odd(G_odd), .B_odd(B_odd),
        .Grant(Grant), .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
        .SRAM_we_n(SRAM_we_n), .Busy(Busy), .Done(Done), .Pair_count(Pair_count)
    );

    always #10 Clock_50 = ~Clock_50;

    typedef struct packed {logic [17:0] addr; logic [15:0] data;} wr_t;
    wr_t         sb[$];
    logic [47:0] offers[$];
    wr_t         mon_e;
    logic [47:0] acc_p;
    logic [47:0] p;
    logic [17:0] last_addr;
    int checks = 0, failures = 0;
    int exp_k = 0, run_len = 0, max_run = 0, write_count = 0, done_count = 0;
    logic rdy [1:6];
    logic exp_rdy [1:6];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Upstream driver: present the head of the offer queue.
    always @(negedge Clock_50) begin
        if (offers.size() > 0 && !Reset) begin
            Pair_valid = 1'b1;
            {R_even, G_even, B_even, R_odd, G_odd, B_odd} = offers[0];
        end else begin
            Pair_valid = 1'b0;
        end
    end

    // Accepted pair -> three expected writes at consecutive addresses.
    always @(posedge Clock_50) begin
        if (!Reset && Pair_valid && Pair_ready) begin
            acc_p = offers.pop_front();
            sb.push_back({OFF + 18'(3 * exp_k),     acc_p[47:32]});
            sb.push_back({OFF + 18'(3 * exp_k + 1), acc_p[31:16]});
            sb.push_back({OFF + 18'(3 * exp_k + 2), acc_p[15:0]});
            exp_k++;
        end
    end

    always @(negedge Clock_50) begin
        if (!Reset && SRAM_we_n == 1'b0) begin
            write_count++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
            last_addr = SRAM_address;
            if (sb.size() == 0) begin
                check_eq("unexpected_write", 32'(SRAM_address), 32'h0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("wr_addr", 32'(SRAM_address), 32'(mon_e.addr));
                check_eq("wr_data", 32'(SRAM_write_data), 32'(mon_e.data));
            end
        end else begin
            run_len = 0;
        end
        if (!Reset && Done) done_count++;
    end

    task automatic reset_dut();
        offers.delete();
        Reset = 1'b1;
        Start = 1'b0;
        repeat (2) @(negedge Clock_50);
        Reset = 1'b0;
        sb.delete();
        write_count = 0;
        max_run = 0;
        run_len = 0;
        done_count = 0;
    endtask

    task automatic start_frame();
        @(negedge Clock_50);
        Start = 1'b1;
        exp_k = 0;
        @(negedge Clock_50);
        Start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((sb.size() != 0 || offers.size() != 0) && n < budget) begin
            @(negedge Clock_50);
            n++;
        end
        check_eq("drain_timeout", 32'(sb.size() + offers.size()), 32'd0);
        @(negedge Clock_50);
    endtask

    task automatic wait_write(input logic [17:0] addr, input int budget);
        int n = 0;
        while (!(SRAM_we_n == 1'b0 && SRAM_address == addr) && n < budget) begin
            @(negedge Clock_50);
            n++;
        end
        check_eq("write_seen_timeout", 32'(n < budget), 32'd1);
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Grant = 1'b1;
        repeat (3) @(negedge Clock_50);
        check_eq("rst_we_n", 32'(SRAM_we_n), 32'd1);
        check_eq("rst_addr", 32'(SRAM_address), 32'd0);
        check_eq("rst_data", 32'(SRAM_write_data), 32'd0);
        check_eq("rst_busy", 32'(Busy), 32'd0);
        check_eq("rst_done", 32'(Done), 32'd0);
        check_eq("rst_ready", 32'(Pair_ready), 32'd0);
        check_eq("rst_count", 32'(Pair_count), 32'd0);
        Reset = 1'b0;

        // Single known pair.
        start_frame();
        offers.push_back({8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60});
        wait_write(OFF, 20);
        check_eq("t1_word0", 32'(SRAM_write_data), 32'h0A14);
        wait_drain(40);
        check_eq("t1_run", 32'(max_run), 32'd3);
        check_eq("t1_writes", 32'(write_count), 32'd3);
        check_eq("t1_count", 32'(Pair_count), 32'd1);
        check_eq("t1_busy", 32'(Busy), 32'd1);
        reset_dut();

        // Four pairs back to back; FIFO fills while the writer drains.
        @(negedge Clock_50);
        Start = 1'b1;
        exp_k = 0;
        for (int i = 0; i < 4; i++) offers.push_back(48'({$urandom(), $urandom()}));
        for (int i = 1; i <= 6; i++) begin
            @(negedge Clock_50);
            if (i == 1) Start = 1'b0;
            rdy[i] = Pair_ready;
        end
        exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 1; i <= 6; i++) check_eq($sformatf("t2_ready_c%0d", i), 32'(rdy[i]), 32'(exp_rdy[i]));
        wait_drain(60);
        check_eq("t2_run", 32'(max_run), 32'd12);
        check_eq("t2_count", 32'(Pair_count), 32'd4);
        reset_dut();

        // Grant withheld for five cycles in W1.
        start_frame();
        p = 48'({$urandom(), $urandom()});
        offers.push_back(p);
        wait_write(OFF, 20);
        Grant = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock_50);
            check_eq("t3_stall_we_n", 32'(SRAM_we_n), 32'd1);
            check_eq("t3_stall_addr", 32'(SRAM_address), 32'(OFF));
            check_eq("t3_stall_data", 32'(SRAM_write_data), 32'(p[47:32]));
        end
        Grant = 1'b1;
        wait_drain(40);
        check_eq("t3_writes", 32'(write_count), 32'd3);
        check_eq("t3_count", 32'(Pair_count), 32'd1);
        reset_dut();

        // Full frame with a mid-frame Start and one surplus pair.
        start_frame();
        for (int i = 0; i <= PP; i++) offers.push_back(48'({$urandom(), $urandom()}));
        repeat (10) @(negedge Clock_50);
        Start = 1'b1;
        @(negedge Clock_50);
        Start = 1'b0;
        check_eq("t4_busy_mid", 32'(Busy), 32'd1);
        for (int n = 0; n < 300 && done_count == 0; n++) @(negedge Clock_50);
        check_eq("t4_done_seen", 32'(done_count), 32'd1);
        repeat (5) @(negedge Clock_50);
        check_eq("t4_done_once", 32'(done_count), 32'd1);
        check_eq("t4_busy", 32'(Busy), 32'd0);
        check_eq("t4_count", 32'(Pair_count), 32'(PP));
        check_eq("t4_last_addr", 32'(last_addr), 32'h3FFFF);
        check_eq("t4_writes", 32'(write_count), 32'(3 * PP));
        check_eq("t4_extra_left", 32'(offers.size()), 32'd1);
        check_eq("t4_sb_empty", 32'(sb.size()), 32'd0);
        check_eq("t4_ready", 32'(Pair_ready), 32'd0);
        reset_dut();

        // Reset in W2 with a full FIFO.
        start_frame();
        for (int i = 0; i < 6; i++) offers.push_back(48'({$urandom(), $urandom()}));
        wait_write(OFF + 18'd1, 30);
        check_eq("t5_ready_full", 32'(Pair_ready), 32'd0);
        #1;
        offers.delete();
        sb.delete();
        Reset = 1'b1;
        @(negedge Clock_50);
        check_eq("t5_we_n", 32'(SRAM_we_n), 32'd1);
        check_eq("t5_busy", 32'(Busy), 32'd0);
        check_eq("t5_ready", 32'(Pair_ready), 32'd0);
        check_eq("t5_count", 32'(Pair_count), 32'd0);
        Reset = 1'b0;
        write_count = 0;
        start_frame();
        offers.push_back(48'({$urandom(), $urandom()}));
        for (int n = 0; n < 20 && SRAM_we_n != 1'b0; n++) @(negedge Clock_50);
        check_eq("t5_first_addr", 32'(SRAM_address), 32'(OFF));
        wait_drain(40);
        check_eq("t5_writes", 32'(write_count), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
